uart_frame_collector: RTL and testbench
=======================================

UART_FRAME_COLLECTOR -- requirements
Module: uart_frame_collector

Interface
REQ-001 Parameter NCH, default 5: number of receive channels (2..16).
REQ-002 Parameter BYTES, default 4: fixed frame length in bytes per channel (2..32).
REQ-003 Parameter TOUT, default 800: inter-byte gap limit in clk cycles (10 us at 80 MHz).
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port frameStart, input, 1: one-cycle pulse at each new request cycle; clears all channels.
REQ-007 Port iValid, input, NCH: per-channel received-byte strobe, one cycle wide.
REQ-008 Port iData, input, NCH*8: per-channel byte; channel k occupies bits [8k+7:8k].
REQ-009 Port oStrob, output, 1: output byte valid.
REQ-010 Port oData, output, 8: output byte.
REQ-011 Port oCh, output, clog2(NCH): source channel of oData.
REQ-012 Port oIdx, output, clog2(BYTES): byte index within the frame.
REQ-013 Port oLast, output, 1: high with the final byte of a frame.
REQ-014 Port busy, output, 1: high while the sequencer is outside IDLE.
REQ-015 Port overrun, output, NCH: sticky flag; a byte arrived while the channel was full.
REQ-016 Port tout, output, NCH: sticky flag; a partial frame was discarded on gap timeout.

Function
REQ-017 Each channel SHALL store bytes at write index wcnt (0..BYTES-1) and increment wcnt on iValid.
REQ-018 A channel SHALL be full when wcnt==BYTES; the full flag is registered one cycle after the completing iValid.
REQ-019 A byte arriving at a full channel SHALL be dropped and SHALL set overrun[k]; stored data is unchanged.
REQ-020 The sequencer SHALL have states IDLE, READ.
REQ-021 In IDLE, the sequencer SHALL select the first full channel at or after the round-robin pointer ptr, wrapping from NCH-1 to 0, and SHALL enter READ.
REQ-022 In READ, the sequencer SHALL emit one byte per cycle, oIdx 0..BYTES-1, with oStrob high for exactly BYTES consecutive cycles.
REQ-023 oLast SHALL assert with oIdx==BYTES-1; in the following cycle the channel's wcnt SHALL clear, ptr SHALL become (channel+1) mod NCH, and the state SHALL return to IDLE.
REQ-024 Latency: if the last byte is sampled in cycle T with the sequencer idle, the first oStrob SHALL occur in cycle T+2.
REQ-025 Back-to-back frames SHALL have exactly one idle cycle of oStrob low between frames.
REQ-026 frameStart SHALL clear every wcnt and abort any READ; oStrob SHALL be low from the next cycle; overrun and tout SHALL also clear.
REQ-027 When frameStart and iValid[k] coincide, frameStart SHALL win and the byte SHALL be discarded.
REQ-028 oData, oCh, oIdx and oLast SHALL be registered and SHALL hold zero when oStrob is low.

Reset
REQ-029 On rst low, all of the following SHALL clear immediately (asynchronously): wcnt, full flags, ptr, state (IDLE), and all outputs; the byte storage need not clear.
REQ-030 On rst release, the first iValid SHALL be accepted in the first clock edge after release.

Configuration
REQ-031 With FRAME_TIMEOUT_EN defined, each channel SHALL count cycles since its last iValid while 0<wcnt<BYTES.
REQ-032 When that count reaches TOUT, the partial frame SHALL be discarded (wcnt=0) and tout[k] SHALL be set.
REQ-033 With FRAME_TIMEOUT_EN undefined, partial frames SHALL be held until frameStart; tout SHALL be tied to zero; no gap counters SHALL exist.

Structure
REQ-034 Package uart_frame_pkg SHALL hold the sequencer state enum, the default parameter constants and the width helper functions.
REQ-035 Sub-module uart_frame_chan SHALL implement one channel: byte storage, wcnt, full flag, overrun flag and the optional timeout counter; the top generates NCH instances and contains the sequencer.

Verification
REQ-036 Channel 2 receives A1 B2 C3 D4 -> two cycles later, 4 strobes with oCh=2, oIdx 0..3, oData A1..D4, and oLast on D4.
REQ-037 Channels 0, 3 and 4 fill in the same cycle, ptr=4 -> frames are emitted in order 4, 0, 3, each separated by one idle cycle.
REQ-038 Channel 1 full, then a 5th byte 0xEE arrives -> overrun[1]=1 and the emitted frame excludes 0xEE.
REQ-039 frameStart asserted during oIdx=1 of a frame -> oStrob goes low the next cycle, busy=0, and no oLast occurs.
REQ-040 FRAME_TIMEOUT_EN defined, TOUT=800, channel 0 receives 2 bytes then stays silent -> tout[0]=1 at gap cycle 800, and a subsequent 4 bytes form a fresh frame.
REQ-041 rst low during READ -> all outputs are zero immediately without a clock edge; after release, a new frame is collected normally.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the UART frame collector:
//   - seqState_t : read sequencer state encoding (IDLE / READ)
//   - DEF_*      : default values for the NCH / BYTES / TOUT parameters
//   - idxWidth() : width of an index into n items (never below 1 bit)
//   - cntWidth() : width of a counter that must hold 0..n inclusive
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  localparam int DEF_NCH   = 5;
  localparam int DEF_BYTES = 4;
  localparam int DEF_TOUT  = 800;  // 10 us at 80 MHz

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } seqState_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_frame_chan.sv
// -----------------------------------------------------------------------------
// uart_frame_chan
// One receive channel: collects BYTES bytes into local storage, flags full,
// flags overrun when a byte arrives while full, and (with FRAME_TIMEOUT_EN
// defined) discards a partial frame after TOUT silent cycles.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clear        frameStart: empties the channel and clears both flags
//   drain        sequencer has emitted this channel's frame; empty it
//   iValid/iData received-byte strobe and byte
//   full         registered: BYTES bytes held
//   overrun      sticky: byte dropped because channel was full
//   tout         sticky: partial frame discarded on gap timeout (0 if disabled)
//   frameData    stored bytes, byte j at [8j+7:8j]
// -----------------------------------------------------------------------------
module uart_frame_chan
  import uart_frame_pkg::*;
#(
  parameter int BYTES = DEF_BYTES,
  parameter int TOUT  = DEF_TOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               drain,
  input  logic               iValid,
  input  logic [7:0]         iData,
  output logic               full,
  output logic               overrun,
  output logic               tout,
  output logic [BYTES*8-1:0] frameData
);

  localparam int WCW = cntWidth(BYTES);
  localparam int IW  = idxWidth(BYTES);
  localparam logic [WCW-1:0] LAST_CNT = WCW'(BYTES - 1);

  logic [WCW-1:0] wcnt;
  logic [7:0]     mem [BYTES];
  logic           accept;
  logic           toutHit;

  // frameStart wins over a coincident byte; a full channel drops the byte.
  assign accept = iValid && !full && !clear;

  // NOTE: payload storage has no reset; wcnt/full decide what is valid, and
  // leaving the RAM unreset lets it map onto plain flops or a memory macro.
  always_ff @(posedge clk) begin
    if (accept) mem[wcnt[IW-1:0]] <= iData;
  end

  for (genvar j = 0; j < BYTES; j++) begin : gPack
    assign frameData[8*j +: 8] = mem[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      wcnt    <= '0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      wcnt    <= '0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (drain) begin
        wcnt <= '0;
        full <= 1'b0;
      end else if (accept) begin
        wcnt <= wcnt + WCW'(1);
        full <= (wcnt == LAST_CNT);
      end else if (toutHit) begin
        wcnt <= '0;
      end
      if (iValid && full) overrun <= 1'b1;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int GW = cntWidth(TOUT);

  logic [GW-1:0] gapCnt;
  logic          partial;
  logic          toutFlag;

  assign partial = (wcnt != '0) && !full;
  // gapCnt holds the number of silent cycles already elapsed, so the limit
  // is reached during the cycle in which it reads TOUT-1.
  assign toutHit = partial && !iValid && (gapCnt == GW'(TOUT - 1));
  assign tout    = toutFlag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gapCnt   <= '0;
      toutFlag <= 1'b0;
    end else if (clear) begin
      gapCnt   <= '0;
      toutFlag <= 1'b0;
    end else begin
      if (accept || toutHit || !partial) gapCnt <= '0;
      else                               gapCnt <= gapCnt + GW'(1);
      if (toutHit) toutFlag <= 1'b1;
    end
  end
`else
  // Without the timeout feature partial frames wait for frameStart.
  localparam int unusedTout = TOUT;
  assign toutHit = 1'b0;
  assign tout    = 1'b0;
`endif

endmodule

// File: rtl/uart_frame_collector.sv
// -----------------------------------------------------------------------------
// uart_frame_collector
// Collects fixed-length frames from NCH UART byte streams and replays each
// completed frame as a burst of BYTES strobed bytes, serving full channels
// round-robin. Optional gap timeout: define FRAME_TIMEOUT_EN.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   frameStart     start of request cycle: clears channels/flags, aborts READ
//   iValid, iData  per-channel byte strobe, channel k byte at [8k+7:8k]
//   oStrob         output byte valid
//   oData/oCh/oIdx byte, source channel, index in frame (zero when idle)
//   oLast          final byte of the frame
//   busy           sequencer in READ
//   overrun, tout  per-channel sticky flags
// -----------------------------------------------------------------------------
module uart_frame_collector
  import uart_frame_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int BYTES = DEF_BYTES,
  parameter int TOUT  = DEF_TOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frameStart,
  input  logic [NCH-1:0]             iValid,
  input  logic [NCH*8-1:0]           iData,
  output logic                       oStrob,
  output logic [7:0]                 oData,
  output logic [idxWidth(NCH)-1:0]   oCh,
  output logic [idxWidth(BYTES)-1:0] oIdx,
  output logic                       oLast,
  output logic                       busy,
  output logic [NCH-1:0]             overrun,
  output logic [NCH-1:0]             tout
);

  localparam int CW = idxWidth(NCH);
  localparam int IW = idxWidth(BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

  seqState_t          state, nextState;
  logic [CW-1:0]      ptr, pickCh, chN;
  logic               found;
  logic [IW-1:0]      idxN;
  logic               strobN, lastN, frameDone;
  logic [7:0]         dataN;
  logic [NCH-1:0]     chFull, drain;
  logic [BYTES*8-1:0] chData [NCH];

  for (genvar k = 0; k < NCH; k++) begin : gChan
    uart_frame_chan #(.BYTES(BYTES), .TOUT(TOUT)) uChan (
      .clk       (clk),
      .rst       (rst),
      .clear     (frameStart),
      .drain     (drain[k]),
      .iValid    (iValid[k]),
      .iData     (iData[8*k +: 8]),
      .full      (chFull[k]),
      .overrun   (overrun[k]),
      .tout      (tout[k]),
      .frameData (chData[k])
    );
  end

  // oCh/oIdx double as the sequencer's read channel and index: they are only
  // non-zero while READ, which is exactly when they are needed.
  assign frameDone = (state == READ) && (oIdx == LAST_IDX) && !frameStart;
  assign busy      = (state != IDLE);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      oStrob <= 1'b0;
      oData  <= '0;
      oCh    <= '0;
      oIdx   <= '0;
      oLast  <= 1'b0;
    end else begin
      state  <= nextState;
      oStrob <= strobN;
      oData  <= dataN;
      oCh    <= chN;
      oIdx   <= idxN;
      oLast  <= lastN;
      if (frameDone) ptr <= (oCh == LAST_CH) ? '0 : oCh + CW'(1);
    end
  end

  // Next state, including the round-robin search from ptr
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    nextState = state;
    found     = 1'b0;
    pickCh    = '0;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (int'(ptr) + i) % NCH;
      if (!found && chFull[c]) begin
        found  = 1'b1;
        pickCh = CW'(c);
      end
    end
    unique case (state)
      IDLE: if (found) nextState = READ;
      READ: if (oIdx == LAST_IDX) nextState = IDLE;
    endcase
    if (frameStart) nextState = IDLE;
  end

  // Next output values; zero whenever the next cycle is not a READ cycle
  always_comb begin
    chN    = '0;
    idxN   = '0;
    strobN = 1'b0;
    dataN  = '0;
    lastN  = 1'b0;
    drain  = '0;
    if (nextState == READ) begin
      strobN = 1'b1;
      if (state == IDLE) begin
        chN  = pickCh;
        idxN = '0;
      end else begin
        chN  = oCh;
        idxN = oIdx + IW'(1);
      end
      dataN = chData[chN][8*int'(idxN) +: 8];
      lastN = (idxN == LAST_IDX);
    end
    if (frameDone) drain[oCh] = 1'b1;
  end

endmodule

// File: tb/tb_uart_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_collector
// Self-checking bench for uart_frame_collector (NCH=5, BYTES=4, TOUT=800).
// Inputs are driven on the falling edge, outputs compared on the next falling
// edge. A queue-style reference model tracks channel contents and the read
// order; define FRAME_TIMEOUT_EN to match a timeout-enabled build.
// -----------------------------------------------------------------------------
module tb_uart_frame_collector;

  localparam int NCH   = 5;
  localparam int BYTES = 4;
  localparam int TOUT  = 800;

  logic             clk;
  logic             rst;
  logic             frameStart;
  logic [NCH-1:0]   iValid;
  logic [NCH*8-1:0] iData;
  logic             oStrob;
  logic [7:0]       oData;
  logic [2:0]       oCh;
  logic [1:0]       oIdx;
  logic             oLast;
  logic             busy;
  logic [NCH-1:0]   overrun;
  logic [NCH-1:0]   tout;

  int errors = 0;
  int checks = 0;

  uart_frame_collector #(.NCH(NCH), .BYTES(BYTES), .TOUT(TOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .frameStart (frameStart),
    .iValid     (iValid),
    .iData      (iData),
    .oStrob     (oStrob),
    .oData      (oData),
    .oCh        (oCh),
    .oIdx       (oIdx),
    .oLast      (oLast),
    .busy       (busy),
    .overrun    (overrun),
    .tout       (tout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         mcnt [NCH];
  logic [7:0] mbuf [NCH][BYTES];
  int         mgap [NCH];
  logic [NCH-1:0] mOvr, mTout;
  bit         mReading;
  int         mCh, mIdx, mPtr;

  task automatic modelReset();
    for (int k = 0; k < NCH; k++) begin
      mcnt[k] = 0;
      mgap[k] = 0;
    end
    mOvr = '0; mTout = '0; mReading = 0; mCh = 0; mIdx = 0; mPtr = 0;
  endtask

  task automatic modelEdge(input logic fs, input logic [NCH-1:0] v, input logic [NCH*8-1:0] d);
    bit preFull [NCH];
    int drainCh;
    for (int k = 0; k < NCH; k++) preFull[k] = (mcnt[k] == BYTES);
    if (fs) begin
      for (int k = 0; k < NCH; k++) begin
        mcnt[k] = 0;
        mgap[k] = 0;
      end
      mOvr = '0; mTout = '0; mReading = 0;
      return;
    end
    drainCh = -1;
    if (mReading) begin
      if (mIdx == BYTES - 1) begin
        mReading = 0;
        drainCh  = mCh;
        mPtr     = (mCh + 1) % NCH;
      end else begin
        mIdx++;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (preFull[(mPtr + i) % NCH]) begin
          mReading = 1;
          mCh      = (mPtr + i) % NCH;
          mIdx     = 0;
          break;
        end
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (v[k]) begin
        if (preFull[k]) mOvr[k] = 1'b1;
        else begin
          mbuf[k][mcnt[k]] = d[8*k +: 8];
          mcnt[k]++;
          mgap[k] = 0;
        end
      end
`ifdef FRAME_TIMEOUT_EN
      else if (mcnt[k] > 0 && mcnt[k] < BYTES) begin
        mgap[k]++;
        if (mgap[k] == TOUT) begin
          mcnt[k]  = 0;
          mgap[k]  = 0;
          mTout[k] = 1'b1;
        end
      end
`endif
    end
    if (drainCh >= 0) mcnt[drainCh] = 0;
  endtask

  task automatic compareModel(input string tag);
    check({tag, " oStrob"},  oStrob,  mReading);
    check({tag, " oData"},   oData,   mReading ? mbuf[mCh][mIdx] : 8'h00);
    check({tag, " oCh"},     oCh,     mReading ? mCh : 0);
    check({tag, " oIdx"},    oIdx,    mReading ? mIdx : 0);
    check({tag, " oLast"},   oLast,   mReading && (mIdx == BYTES - 1));
    check({tag, " busy"},    busy,    mReading);
    check({tag, " overrun"}, overrun, mOvr);
    check({tag, " tout"},    tout,    mTout);
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock cycle: drive at the falling edge, return at the next falling edge.
  task automatic step(input logic fs, input logic [NCH-1:0] v, input logic [NCH*8-1:0] d);
    frameStart = fs; iValid = v; iData = d;
    modelEdge(fs, v, d);
    @(posedge clk);
    #1;
    frameStart = 1'b0; iValid = '0; iData = '0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] dataFor(input int k, input int j);
    return 8'(((k + 1) << 4) | (j + 1));
  endfunction

  function automatic logic [NCH*8-1:0] chByte(input int k, input logic [7:0] b);
    logic [NCH*8-1:0] r;
    r = '0;
    r[8*k +: 8] = b;
    return r;
  endfunction

  task automatic fillMulti(input logic [NCH-1:0] mask);
    for (int j = 0; j < BYTES; j++) begin
      logic [NCH*8-1:0] d;
      d = '0;
      for (int k = 0; k < NCH; k++) if (mask[k]) d[8*k +: 8] = dataFor(k, j);
      step(1'b0, mask, d);
    end
  endtask

  task automatic expectFrame(input string tag, input int k, input int first);
    for (int j = first; j < BYTES; j++) begin
      step(1'b0, '0, '0);
      check($sformatf("%s oStrob[%0d]", tag, j), oStrob, 1);
      check($sformatf("%s oCh[%0d]", tag, j),    oCh,    k);
      check($sformatf("%s oIdx[%0d]", tag, j),   oIdx,   j);
      check($sformatf("%s oData[%0d]", tag, j),  oData,  dataFor(k, j));
      check($sformatf("%s oLast[%0d]", tag, j),  oLast,  (j == BYTES - 1));
    end
  endtask

  task automatic expectIdle(input string tag);
    step(1'b0, '0, '0);
    check({tag, " idle oStrob"}, oStrob, 0);
    check({tag, " idle busy"},   busy,   0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             fs;
    logic [NCH-1:0]   v;
    logic [NCH*8-1:0] d;
    logic             strob;
    logic [7:0]       data;
    logic [2:0]       ch;
    logic [1:0]       idx;
    logic             last;
    logic             bsy;
  } vec_t;

  function automatic vec_t mk(input logic fs, input logic [NCH-1:0] v, input logic [NCH*8-1:0] d,
                              input logic s, input logic [7:0] data, input logic [2:0] ch,
                              input logic [1:0] idx, input logic last, input logic bsy);
    vec_t r;
    r.fs = fs; r.v = v; r.d = d; r.strob = s; r.data = data;
    r.ch = ch; r.idx = idx; r.last = last; r.bsy = bsy;
    return r;
  endfunction

  vec_t vecs [10];

  initial begin
    int cnt;
    rst = 1'b1; frameStart = 1'b0; iValid = '0; iData = '0;
    modelReset();

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("reset oStrob",  oStrob,  0);
    check("reset oData",   oData,   0);
    check("reset oCh",     oCh,     0);
    check("reset oIdx",    oIdx,    0);
    check("reset oLast",   oLast,   0);
    check("reset busy",    busy,    0);
    check("reset overrun", overrun, 0);
    check("reset tout",    tout,    0);
    @(negedge clk);
    rst = 1'b1;

    // Channel 2 frame A1 B2 C3 D4: first strobe two cycles after the last byte
    vecs[0] = mk(0, 5'b00100, chByte(2, 8'hA1), 0, 8'h00, 0, 0, 0, 0);
    vecs[1] = mk(0, 5'b00100, chByte(2, 8'hB2), 0, 8'h00, 0, 0, 0, 0);
    vecs[2] = mk(0, 5'b00100, chByte(2, 8'hC3), 0, 8'h00, 0, 0, 0, 0);
    vecs[3] = mk(0, 5'b00100, chByte(2, 8'hD4), 0, 8'h00, 0, 0, 0, 0);
    vecs[4] = mk(0, 5'b00000, '0,               1, 8'hA1, 2, 0, 0, 1);
    vecs[5] = mk(0, 5'b00000, '0,               1, 8'hB2, 2, 1, 0, 1);
    vecs[6] = mk(0, 5'b00000, '0,               1, 8'hC3, 2, 2, 0, 1);
    vecs[7] = mk(0, 5'b00000, '0,               1, 8'hD4, 2, 3, 1, 1);
    vecs[8] = mk(0, 5'b00000, '0,               0, 8'h00, 0, 0, 0, 0);
    vecs[9] = mk(0, 5'b00000, '0,               0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].fs, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d oStrob", i), oStrob, vecs[i].strob);
      check($sformatf("vec%0d oData", i),  oData,  vecs[i].data);
      check($sformatf("vec%0d oCh", i),    oCh,    vecs[i].ch);
      check($sformatf("vec%0d oIdx", i),   oIdx,   vecs[i].idx);
      check($sformatf("vec%0d oLast", i),  oLast,  vecs[i].last);
      check($sformatf("vec%0d busy", i),   busy,   vecs[i].bsy);
    end

    // Channel 3 frame moves ptr to 4; then 0, 3, 4 fill together -> 4, 0, 3
    fillMulti(5'b01000);
    expectFrame("ch3", 3, 0);
    expectIdle("ch3");
    fillMulti(5'b11001);
    expectFrame("rr4", 4, 0);
    expectIdle("rr4");
    expectFrame("rr0", 0, 0);
    expectIdle("rr0");
    expectFrame("rr3", 3, 0);
    expectIdle("rr3");

    // Overrun: 0xEE arrives at full channel 1, frame excludes it
    fillMulti(5'b00010);
    step(1'b0, 5'b00010, chByte(1, 8'hEE));
    check("ovr overrun", overrun, 5'b00010);
    check("ovr oStrob0", oStrob, 1);
    check("ovr oData0",  oData,  dataFor(1, 0));
    expectFrame("ovr", 1, 1);
    expectIdle("ovr");

    // Abort at oIdx=1 with a coincident byte on channel 0 (discarded)
    fillMulti(5'b00100);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    check("abort pre oIdx", oIdx, 1);
    step(1'b1, 5'b00001, chByte(0, 8'h77));
    check("abort oStrob",  oStrob,  0);
    check("abort busy",    busy,    0);
    check("abort oLast",   oLast,   0);
    check("abort overrun", overrun, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0);
      if (oStrob || oLast) cnt++;
    end
    check("abort no strobes", cnt, 0);
    fillMulti(5'b00001);
    expectFrame("postabort", 0, 0);
    expectIdle("postabort");

    // Reset during READ: outputs clear without a clock edge
    fillMulti(5'b10000);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    check("rstread pre oStrob", oStrob, 1);
    rst = 1'b0;
    modelReset();
    #1;
    check("rstread oStrob", oStrob, 0);
    check("rstread oData",  oData,  0);
    check("rstread oCh",    oCh,    0);
    check("rstread oIdx",   oIdx,   0);
    check("rstread oLast",  oLast,  0);
    check("rstread busy",   busy,   0);
    @(negedge clk);
    rst = 1'b1;
    fillMulti(5'b00010);
    expectFrame("postrst", 1, 0);
    expectIdle("postrst");

    // Gap timeout on a two-byte partial frame on channel 0
    step(1'b0, 5'b00001, chByte(0, dataFor(0, 0)));
    step(1'b0, 5'b00001, chByte(0, dataFor(0, 1)));
`ifdef FRAME_TIMEOUT_EN
    repeat (TOUT - 1) step(1'b0, '0, '0);
    check("tout before limit", tout, 5'b00000);
    step(1'b0, '0, '0);
    check("tout at limit", tout, 5'b00001);
    fillMulti(5'b00001);
    expectFrame("tout fresh", 0, 0);
`else
    repeat (TOUT + 5) step(1'b0, '0, '0);
    check("held tout", tout, 5'b00000);
    check("held oStrob", oStrob, 0);
    step(1'b0, 5'b00001, chByte(0, dataFor(0, 2)));
    step(1'b0, 5'b00001, chByte(0, dataFor(0, 3)));
    expectFrame("held", 0, 0);
`endif
    expectIdle("tout");

    // Randomized traffic against the reference model
    step(1'b1, '0, '0);
    for (int n = 0; n < 3000; n++) begin
      logic             fs;
      logic [NCH-1:0]   v;
      logic [NCH*8-1:0] d;
      fs = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NCH; k++) begin
        v[k] = ($urandom_range(0, 2) == 0);
        d[8*k +: 8] = 8'($urandom);
      end
      step(fs, v, d);
      compareModel($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
